// File: rtl/decode.sv
// Decode stage: register file with write-through bypass, RV32I immediate
// decode, load-use hazard detection and the ID/EX pipeline register.
//
// Ports
//   clk, rstn         clock, asynchronous active-low reset
//   fetch_dec_reg     {instruction[63:32], pc[31:0]} from fetch
//   stall             hold ID/EX
//   flush             squash the instruction in decode (bubble)
//   wb_en/addr/data   register-file write port from writeback
//   load_stall        combinational load-use hazard, fetch holds pc
//   ex_*              registered ID/EX fields for the execute stage
module decode #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] fetch_dec_reg,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        load_stall,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1_data,
  output logic [31:0] ex_rs2_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [6:0]  ex_opcode,
  output logic [2:0]  ex_funct3,
  output logic        ex_funct7b5
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
  } idex_t;

  function automatic logic [31:0] imm_of(input logic [31:0] i);
    case (i[6:0])
      OP_LOAD, OP_IMM, OP_JALR: imm_of = {{20{i[31]}}, i[31:20]};
      OP_STORE:                 imm_of = {{20{i[31]}}, i[31:25], i[11:7]};
      OP_BR:     imm_of = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm_of = {i[31:12], 12'b0};
      OP_JAL:    imm_of = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:                  imm_of = '0;
    endcase
  endfunction

  logic [31:0] regs [32];
  logic [31:0] instr, pc;
  logic [4:0]  rs1, rs2;
  logic [31:0] rs1_data, rs2_data;
  logic        uses_rs1, uses_rs2;
  idex_t       ex, dec, bub;

  assign instr = fetch_dec_reg[63:32];
  assign pc    = fetch_dec_reg[31:0];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];

  // x0 is never written, so regs[0] stays at its reset value of zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Same-cycle writeback bypass so decode never sees a stale operand.
  always_comb begin
    rs1_data = regs[rs1];
    rs2_data = regs[rs2];
    if (wb_en && wb_addr != 5'd0 && wb_addr == rs1) rs1_data = wb_data;
    if (wb_en && wb_addr != 5'd0 && wb_addr == rs2) rs2_data = wb_data;
    if (rs1 == 5'd0) rs1_data = '0;
    if (rs2 == 5'd0) rs2_data = '0;
  end

  assign uses_rs1 = !(instr[6:0] == OP_LUI || instr[6:0] == OP_AUIPC ||
                      instr[6:0] == OP_JAL);
  assign uses_rs2 = (instr[6:0] == OP_REG || instr[6:0] == OP_STORE ||
                     instr[6:0] == OP_BR);

  // The bubble this raises clears ex_valid, so it self-terminates after a cycle.
  assign load_stall = ex.valid && ex.opcode == OP_LOAD && ex.rd != 5'd0 &&
                      ((uses_rs1 && ex.rd == rs1) || (uses_rs2 && ex.rd == rs2));

  always_comb begin
    dec          = '0;
    dec.valid    = 1'b1;
    dec.pc       = pc;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
    dec.imm      = imm_of(instr);
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.rd       = instr[11:7];
    dec.opcode   = instr[6:0];
    dec.funct3   = instr[14:12];
    dec.funct7b5 = instr[30];

    // Bubble carries the NOP's fields but no pc or operand data.
    bub          = '0;
    bub.imm      = imm_of(NOP_INST);
    bub.rs1      = NOP_INST[19:15];
    bub.rs2      = NOP_INST[24:20];
    bub.rd       = NOP_INST[11:7];
    bub.opcode   = NOP_INST[6:0];
    bub.funct3   = NOP_INST[14:12];
    bub.funct7b5 = NOP_INST[30];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                     ex <= '0;
    else if (flush || load_stall)  ex <= bub;
    else if (!stall)               ex <= dec;
  end

  assign ex_valid    = ex.valid;
  assign ex_pc       = ex.pc;
  assign ex_rs1_data = ex.rs1_data;
  assign ex_rs2_data = ex.rs2_data;
  assign ex_imm      = ex.imm;
  assign ex_rs1      = ex.rs1;
  assign ex_rs2      = ex.rs2;
  assign ex_rd       = ex.rd;
  assign ex_opcode   = ex.opcode;
  assign ex_funct3   = ex.funct3;
  assign ex_funct7b5 = ex.funct7b5;

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for decode: reset, decode fields, x0/bypass,
// immediates, load-use hazards, control priority and mid-flight reset.
module tb_decode;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] fetch_dec_reg;
  logic        stall, flush, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        load_stall, ex_valid, ex_funct7b5;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;

  int checks = 0;
  int errors = 0;

  // Instruction encodings used below
  localparam logic [31:0] ADDI_X1_5   = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] ADD_X3_X0   = 32'h0000_01B3; // add x3,x0,x0
  localparam logic [31:0] ADD_X3_X2   = 32'h0021_01B3; // add x3,x2,x2
  localparam logic [31:0] ADD_X2_X1   = 32'h0000_8133; // add x2,x1,x0
  localparam logic [31:0] LW_X5       = 32'h0000_A283; // lw x5,0(x1)
  localparam logic [31:0] LW_X8       = 32'h0000_A403; // lw x8,0(x1)
  localparam logic [31:0] LW_X0       = 32'h0000_A003; // lw x0,0(x1)
  localparam logic [31:0] ADD_X6_X5R1 = 32'h0002_8333; // add x6,x5,x0
  localparam logic [31:0] ADD_X6_X5R2 = 32'h0050_0333; // add x6,x0,x5
  localparam logic [31:0] ADD_X6_X0   = 32'h0000_0333; // add x6,x0,x0
  localparam logic [31:0] LUI_X1      = 32'h1234_50B7; // lui x1,0x12345 (rs1 field = 8)
  localparam logic [31:0] ADD_X8_X7   = 32'h0003_8433; // add x8,x7,x0

  decode #(.NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rstn(rstn), .fetch_dec_reg(fetch_dec_reg), .stall(stall),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .load_stall(load_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] i, input logic [31:0] p);
    fetch_dec_reg = {i, p};
  endtask

  task automatic test_reset();
    #2;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", ex_valid); end
    checks++; if (ex_opcode !== 7'd0) begin errors++; $display("FAIL rst_opcode got %0h exp 0", ex_opcode); end
    checks++; if (ex_imm !== 32'd0) begin errors++; $display("FAIL rst_imm got %0h exp 0", ex_imm); end
    checks++; if (load_stall !== 1'b0) begin errors++; $display("FAIL rst_load_stall got %0h exp 0", load_stall); end
    fetch(ADDI_X1_5, 32'h10);
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_held_valid got %0h exp 0", ex_valid); end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL rst_first_capture got %0h exp 1", ex_valid); end
    checks++; if (ex_pc !== 32'h10) begin errors++; $display("FAIL rst_first_pc got %0h exp 10", ex_pc); end
  endtask

  task automatic test_decode();
    fetch(ADDI_X1_5, 32'h10);
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL dec_valid got %0h exp 1", ex_valid); end
    checks++; if (ex_pc !== 32'h10) begin errors++; $display("FAIL dec_pc got %0h exp 10", ex_pc); end
    checks++; if (ex_rd !== 5'd1) begin errors++; $display("FAIL dec_rd got %0h exp 1", ex_rd); end
    checks++; if (ex_imm !== 32'd5) begin errors++; $display("FAIL dec_imm got %0h exp 5", ex_imm); end
    checks++; if (ex_opcode !== 7'b0010011) begin errors++; $display("FAIL dec_opcode got %0h exp 13", ex_opcode); end
    // back-to-back capture
    fetch(ADD_X3_X2, 32'h14);
    tick();
    checks++; if (ex_pc !== 32'h14) begin errors++; $display("FAIL b2b_pc got %0h exp 14", ex_pc); end
    checks++; if (ex_rd !== 5'd3 || ex_rs1 !== 5'd2 || ex_rs2 !== 5'd2) begin errors++; $display("FAIL b2b_regs got rd %0d rs1 %0d rs2 %0d exp 3 2 2", ex_rd, ex_rs1, ex_rs2); end
    checks++; if (ex_opcode !== 7'b0110011) begin errors++; $display("FAIL b2b_opcode got %0h exp 33", ex_opcode); end
  endtask

  task automatic test_x0_bypass();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
    fetch(ADD_X3_X0, 32'h20);
    tick();
    checks++; if (ex_rs1_data !== 32'd0) begin errors++; $display("FAIL x0_bypass got %0h exp 0", ex_rs1_data); end
    wb_en = 1'b0;
    fetch(ADD_X3_X0, 32'h24);
    tick();
    checks++; if (ex_rs1_data !== 32'd0 || ex_rs2_data !== 32'd0) begin errors++; $display("FAIL x0_read got %0h %0h exp 0 0", ex_rs1_data, ex_rs2_data); end
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h1234;
    fetch(ADD_X3_X2, 32'h28);
    tick();
    checks++; if (ex_rs1_data !== 32'h1234 || ex_rs2_data !== 32'h1234) begin errors++; $display("FAIL bypass got %0h %0h exp 1234 1234", ex_rs1_data, ex_rs2_data); end
    wb_en = 1'b0;
    fetch(ADD_X3_X2, 32'h2C);
    tick();
    checks++; if (ex_rs1_data !== 32'h1234) begin errors++; $display("FAIL rf_stored got %0h exp 1234", ex_rs1_data); end
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h5678;
    fetch(ADD_X3_X2, 32'h30);
    tick();
    checks++; if (ex_rs2_data !== 32'h5678) begin errors++; $display("FAIL bypass_over_rf got %0h exp 5678", ex_rs2_data); end
    wb_en = 1'b0;
  endtask

  task automatic test_imm();
    logic [31:0] ins [6];
    logic [31:0] exp [6];
    ins[0] = 32'hFE00_0CE3; exp[0] = 32'hFFFF_FFF8; // beq x0,x0,-8
    ins[1] = 32'h1234_50B7; exp[1] = 32'h1234_5000; // lui x1,0x12345
    ins[2] = 32'hFE20_AE23; exp[2] = 32'hFFFF_FFFC; // sw x2,-4(x1)
    ins[3] = 32'h0080_00EF; exp[3] = 32'h0000_0008; // jal x1,8
    ins[4] = 32'hFFF0_0093; exp[4] = 32'hFFFF_FFFF; // addi x1,x0,-1
    ins[5] = 32'hFFFF_FFFF; exp[5] = 32'h0000_0000; // unknown opcode
    for (int k = 0; k < 6; k++) begin
      fetch(ins[k], 32'h100 + 32'(k * 4));
      tick();
      checks++; if (ex_imm !== exp[k]) begin errors++; $display("FAIL imm_%0d got %0h exp %0h", k, ex_imm, exp[k]); end
    end
  endtask

  task automatic test_load_use();
    fetch(LW_X5, 32'h40);
    tick();
    checks++; if (load_stall !== 1'b0) begin errors++; $display("FAIL lu_after_lw got %0h exp 0", load_stall); end
    fetch(ADD_X6_X5R1, 32'h44);
    #1;
    checks++; if (load_stall !== 1'b1) begin errors++; $display("FAIL lu_rs1_stall got %0h exp 1", load_stall); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'd0 || ex_opcode !== 7'h13) begin errors++; $display("FAIL lu_bubble got v %0h pc %0h op %0h exp 0 0 13", ex_valid, ex_pc, ex_opcode); end
    checks++; if (load_stall !== 1'b0) begin errors++; $display("FAIL lu_one_cycle got %0h exp 0", load_stall); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h44 || ex_rd !== 5'd6) begin errors++; $display("FAIL lu_resume got v %0h pc %0h rd %0d exp 1 44 6", ex_valid, ex_pc, ex_rd); end
    fetch(LW_X5, 32'h48);
    tick();
    fetch(ADD_X6_X0, 32'h4C);
    #1;
    checks++; if (load_stall !== 1'b0) begin errors++; $display("FAIL lu_no_dep got %0h exp 0", load_stall); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h4C) begin errors++; $display("FAIL lu_no_dep_cap got v %0h pc %0h exp 1 4c", ex_valid, ex_pc); end
    fetch(LW_X5, 32'h50);
    tick();
    fetch(ADD_X6_X5R2, 32'h54);
    #1;
    checks++; if (load_stall !== 1'b1) begin errors++; $display("FAIL lu_rs2_stall got %0h exp 1", load_stall); end
    tick();
    tick();
    fetch(LW_X8, 32'h58);
    tick();
    fetch(LUI_X1, 32'h5C);
    #1;
    checks++; if (load_stall !== 1'b0) begin errors++; $display("FAIL lu_lui_no_rs1 got %0h exp 0", load_stall); end
    tick();
    fetch(LW_X0, 32'h60);
    tick();
    fetch(ADD_X6_X0, 32'h64);
    #1;
    checks++; if (load_stall !== 1'b0) begin errors++; $display("FAIL lu_rd_x0 got %0h exp 0", load_stall); end
    tick();
  endtask

  task automatic test_priority();
    fetch(ADDI_X1_5, 32'h60);
    tick();
    flush = 1'b1; stall = 1'b1;
    fetch(ADD_X3_X0, 32'h64);
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'd0 || ex_opcode !== 7'h13 || ex_imm !== 32'd0) begin errors++; $display("FAIL pri_flush_stall got v %0h pc %0h op %0h imm %0h exp 0 0 13 0", ex_valid, ex_pc, ex_opcode, ex_imm); end
    flush = 1'b0; stall = 1'b0;
    fetch(ADDI_X1_5, 32'h68);
    tick();
    stall = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    fetch(ADD_X3_X2, 32'h6C);
    for (int k = 0; k < 3; k++) begin
      tick();
      wb_en = 1'b0;
      checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h68 || ex_imm !== 32'd5 || ex_rd !== 5'd1) begin errors++; $display("FAIL pri_stall_hold_%0d got v %0h pc %0h imm %0h rd %0d exp 1 68 5 1", k, ex_valid, ex_pc, ex_imm, ex_rd); end
    end
    stall = 1'b0;
    fetch(ADD_X8_X7, 32'h70);
    tick();
    checks++; if (ex_rs1_data !== 32'h77 || ex_pc !== 32'h70) begin errors++; $display("FAIL pri_wb_in_stall got %0h pc %0h exp 77 70", ex_rs1_data, ex_pc); end
    fetch(LW_X5, 32'h74);
    tick();
    fetch(ADD_X6_X5R1, 32'h78);
    flush = 1'b1;
    #1;
    checks++; if (load_stall !== 1'b1) begin errors++; $display("FAIL pri_flush_lu_flag got %0h exp 1", load_stall); end
    tick();
    flush = 1'b0;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL pri_flush_lu_bubble got %0h exp 0", ex_valid); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h78) begin errors++; $display("FAIL pri_flush_lu_resume got v %0h pc %0h exp 1 78", ex_valid, ex_pc); end
    fetch(LW_X5, 32'h7C);
    tick();
    stall = 1'b1;
    fetch(ADD_X6_X5R1, 32'h80);
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'd0) begin errors++; $display("FAIL pri_lu_over_stall got v %0h pc %0h exp 0 0", ex_valid, ex_pc); end
    stall = 1'b0;
    tick();
  endtask

  task automatic test_reset_midflight();
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h55;
    fetch(ADDI_X1_5, 32'h90);
    tick();
    wb_en = 1'b0;
    rstn = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'd0 || ex_imm !== 32'd0 || ex_opcode !== 7'd0 || ex_rd !== 5'd0) begin errors++; $display("FAIL mid_rst_clear got v %0h pc %0h imm %0h op %0h rd %0d exp all 0", ex_valid, ex_pc, ex_imm, ex_opcode, ex_rd); end
    rstn = 1'b1;
    fetch(ADD_X2_X1, 32'h94);
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_rs1_data !== 32'd0) begin errors++; $display("FAIL mid_rst_rf got v %0h rs1_data %0h exp 1 0", ex_valid, ex_rs1_data); end
    fetch(LW_X5, 32'h98);
    tick();
    fetch(ADD_X6_X5R1, 32'h9C);
    #1;
    rstn = 1'b0;
    #1;
    checks++; if (load_stall !== 1'b0 || ex_valid !== 1'b0) begin errors++; $display("FAIL mid_hazard_rst got ls %0h v %0h exp 0 0", load_stall, ex_valid); end
    rstn = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h9C || load_stall !== 1'b0) begin errors++; $display("FAIL mid_hazard_resume got v %0h pc %0h ls %0h exp 1 9c 0", ex_valid, ex_pc, load_stall); end
    stall = 1'b1;
    rstn = 1'b0;
    #1;
    rstn = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_pc !== 32'd0) begin errors++; $display("FAIL mid_stall_rst got v %0h pc %0h exp 0 0", ex_valid, ex_pc); end
    stall = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; stall = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    fetch_dec_reg = {32'h0000_0013, 32'h0};
    test_reset();
    test_decode();
    test_x0_bypass();
    test_imm();
    test_load_use();
    test_priority();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
